casez_req_scheduler: RTL

//  Sequential request scheduler that sits upstream of the casez priority-encoder stage.
//  - Accumulates 4 request lines into a pending register.
//  - Selects the highest-priority pending request with a casez match; bit3 has the highest priority.
//  - Offers the selected request as a 2-bit code over a valid/ready handshake.
//  - Retires each request once the consumer accepts it.

---
 rtl/casez_req_scheduler_pkg.sv | 20 ++
 rtl/casez_req_scheduler_prio_enc.sv | 22 ++
 rtl/casez_req_scheduler.sv | 126 ++++++++++++
 3 files changed

// File: rtl/casez_req_scheduler_pkg.sv
// Shared types and helpers for the casez request scheduler.
package casez_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OFFER = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [1:0] IDX3 = 2'd3;
  localparam logic [1:0] IDX2 = 2'd2;
  localparam logic [1:0] IDX1 = 2'd1;
  localparam logic [1:0] IDX0 = 2'd0;

  // One-hot mask for a 2-bit request index.
  function automatic logic [3:0] onehot4(input logic [1:0] code);
    onehot4 = 4'b0001 << code;
  endfunction

endpackage

// File: rtl/casez_req_scheduler_prio_enc.sv
// Combinational priority selector over the pending requests; bit3 wins.
module casez_prio_enc
  import casez_sched_pkg::*;
(
  input  logic [3:0] pending,
  output logic       hit,
  output logic [1:0] idx
);

  always_comb begin
    hit = 1'b1;
    idx = IDX0;
    casez (pending)
      4'b1???: idx = IDX3;
      4'b01??: idx = IDX2;
      4'b001?: idx = IDX1;
      4'b0001: idx = IDX0;
      default: hit = 1'b0;
    endcase
  end

endmodule

// File: rtl/casez_req_scheduler.sv
// Request scheduler: pending register, casez priority pick, valid/ready offer, post-grant gap.
// Optional per-index grant counters when CASEZ_SCHED_STATS_EN is defined.
module casez_req_scheduler
  import casez_sched_pkg::*;
#(
  parameter int unsigned GAP_CYCLES = 2
`ifdef CASEZ_SCHED_STATS_EN
  ,
  parameter int unsigned CNT_W = 8
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req_in,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [1:0] out_code,
  output logic [3:0] pending,
  output logic       busy
`ifdef CASEZ_SCHED_STATS_EN
  ,
  output logic [4*CNT_W-1:0] grant_cnt
`endif
);

  localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t           state;
  state_t           state_nxt;
  logic [GAP_W-1:0] gap_cnt;
  logic [GAP_W-1:0] gap_cnt_nxt;
  logic             out_valid_nxt;
  logic [1:0]       out_code_nxt;
  logic             hit;
  logic [1:0]       sel_idx;
  logic             hs;
  logic [3:0]       clr_mask;
  logic [3:0]       pending_nxt;

  casez_prio_enc u_prio_enc (
    .pending (pending),
    .hit     (hit),
    .idx     (sel_idx)
  );

  assign hs          = out_valid & out_ready;
  assign clr_mask    = hs ? onehot4(out_code) : 4'b0000;
  // A request arriving on its own retire edge re-queues it.
  assign pending_nxt = (pending & ~clr_mask) | req_in;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (hit) state_nxt = OFFER;
      OFFER:   if (hs) state_nxt = (GAP_CYCLES > 0) ? GAP : IDLE;
      GAP:     if (gap_cnt == GAP_LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Offer is latched in IDLE and frozen until the consumer takes it.
  always_comb begin
    out_valid_nxt = out_valid;
    out_code_nxt  = out_code;
    gap_cnt_nxt   = gap_cnt;
    case (state)
      IDLE: begin
        if (hit) begin
          out_valid_nxt = 1'b1;
          out_code_nxt  = sel_idx;
        end
      end
      OFFER: begin
        if (hs) begin
          out_valid_nxt = 1'b0;
          gap_cnt_nxt   = '0;
        end
      end
      GAP: begin
        gap_cnt_nxt = (gap_cnt == GAP_LAST) ? '0 : gap_cnt + GAP_W'(1);
      end
      default: begin
        out_valid_nxt = 1'b0;
        gap_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending   <= 4'b0000;
      out_valid <= 1'b0;
      out_code  <= IDX0;
      gap_cnt   <= '0;
      busy      <= 1'b0;
    end else begin
      pending   <= pending_nxt;
      out_valid <= out_valid_nxt;
      out_code  <= out_code_nxt;
      gap_cnt   <= gap_cnt_nxt;
      busy      <= (state_nxt != IDLE);
    end
  end

`ifdef CASEZ_SCHED_STATS_EN
  // Saturating per-index grant counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt <= '0;
    end else if (hs) begin
      for (int i = 0; i < 4; i++) begin
        if (out_code == 2'(i) && grant_cnt[CNT_W*i +: CNT_W] != {CNT_W{1'b1}}) begin
          grant_cnt[CNT_W*i +: CNT_W] <= grant_cnt[CNT_W*i +: CNT_W] + CNT_W'(1);
        end
      end
    end
  end
`endif

endmodule
